// File: rtl/serial_subtractor_32bit.sv
// Bit-serial two's-complement subtractor: in1 - in2 - b_in, one bit per clock,
// LSB first, through a single full-adder cell behind a start/done handshake.
module serial_subtractor_32bit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_r;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic w_accept;
    logic w_last;
    logic w_bn;
    logic w_sum;
    logic w_cout;

    assign w_accept = start & (r_state != S_RUN);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // Subtraction as addition of the inverted subtrahend
    assign w_bn   = ~r_b[0];
    assign w_sum  = r_a[0] ^ w_bn ^ r_carry;
    assign w_cout = (r_a[0] & w_bn) | (r_carry & (r_a[0] ^ w_bn));

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_r      <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            diff     <= '0;
            b_out    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_a     <= in1;
                        r_b     <= in2;
                        r_carry <= ~b_in;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_r     <= {w_sum, r_r[WIDTH-1:1]};
                    r_carry <= w_cout;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_cnt   <= r_cnt + CW'(1);
                    // On the MSB cycle r_a[0]/r_b[0] hold the operand sign bits
                    if (w_last) begin
                        diff     <= {w_sum, r_r[WIDTH-1:1]};
                        b_out    <= ~w_cout;
                        overflow <= (r_a[0] ^ r_b[0]) & (w_sum ^ r_a[0]);
                        r_state  <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
